// File: rtl/counter_sched_pkg.sv
// Shared types and helpers for the round-robin counter scheduler.
package counter_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int MAX_NREQ = 16;

  function automatic logic [MAX_NREQ-1:0] onehot(input int unsigned idx, input int unsigned nreq);
    logic [MAX_NREQ-1:0] v;
    v = '0;
    if ((idx < nreq) && (idx < MAX_NREQ)) v[idx[3:0]] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/counter_sched_rr_pick.sv
// Combinational round-robin picker: first set req bit at or above ptr, wrapping.
module rr_pick #(
  parameter int NREQ = 4,
  parameter int PW   = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic            valid,
  output logic [PW-1:0]   idx
);

  logic [NREQ-1:0] w_rot;
  logic [PW-1:0]   w_enc;
  logic [PW:0]     w_sum;

  // Rotating the doubled vector puts the ptr position at bit 0.
  assign w_rot = NREQ'({req, req} >> ptr);

  always_comb begin
    w_enc = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (w_rot[i]) w_enc = PW'(i);
    end
  end

  assign w_sum = {1'b0, w_enc} + {1'b0, ptr};
  assign idx   = (w_sum >= (PW+1)'(NREQ)) ? PW'(w_sum - (PW+1)'(NREQ)) : w_sum[PW-1:0];
  assign valid = |req;

endmodule

// File: rtl/counter_sched.sv
// Shares one up-counter among NREQ requesters, granting round-robin and
// pulsing done for one cycle when the granted interval has elapsed.
module counter_sched
  import counter_sched_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int NREQ  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] len,
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       done,
  output logic                  busy,
  output logic [WIDTH-1:0]      count
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_t            r_state;
  logic [PW-1:0]     r_ptr;
  logic [PW-1:0]     r_owner;
  logic [WIDTH-1:0]  r_tgt;
  logic [WIDTH-1:0]  r_count;
  logic [NREQ-1:0]   r_gnt;
  logic [NREQ-1:0]   r_done;
  logic              r_busy;

  logic              w_valid;
  logic [PW-1:0]     w_idx;
  logic [WIDTH-1:0]  w_len_sel;
  logic [PW-1:0]     w_ptr_next;
  logic              w_own_req;

  rr_pick #(.NREQ(NREQ), .PW(PW)) u_pick (
    .req   (req),
    .ptr   (r_ptr),
    .valid (w_valid),
    .idx   (w_idx)
  );

  always_comb begin
    w_len_sel = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_idx == PW'(i)) w_len_sel = len[i*WIDTH +: WIDTH];
    end
  end

  assign w_ptr_next = (r_owner == PW'(NREQ - 1)) ? '0 : r_owner + PW'(1);
  assign w_own_req  = req[r_owner];

  // Handshake: a requester holds req high; gnt rises one edge after it is
  // seen in IDLE and stays high while count walks 0..tgt. Dropping req
  // before count reaches tgt aborts the run without a done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_owner <= '0;
      r_tgt   <= '0;
      r_count <= '0;
      r_gnt   <= '0;
      r_done  <= '0;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_valid) begin
            r_gnt   <= NREQ'(onehot(32'(w_idx), NREQ));
            r_owner <= w_idx;
            r_tgt   <= w_len_sel;
            r_count <= '0;
            r_busy  <= 1'b1;
            r_state <= RUN;
          end
        end
        RUN: begin
          // Completion takes priority over a simultaneous req drop.
          if (r_count == r_tgt) begin
            r_state <= DONE;
            r_gnt   <= '0;
            r_done  <= NREQ'(onehot(32'(r_owner), NREQ));
            r_ptr   <= w_ptr_next;
          end else if (!w_own_req) begin
            r_state <= IDLE;
            r_gnt   <= '0;
            r_count <= '0;
            r_busy  <= 1'b0;
            r_ptr   <= w_ptr_next;
          end else begin
            r_count <= r_count + WIDTH'(1);
          end
        end
        DONE: begin
          r_done  <= '0;
          r_count <= '0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign gnt   = r_gnt;
  assign done  = r_done;
  assign busy  = r_busy;
  assign count = r_count;

endmodule

// File: tb/tb_counter_sched.sv
// Bench for counter_sched: directed scenarios plus random traffic, checked
// every cycle against an interval-level model of the scheduler.
module tb_counter_sched;

  localparam int WIDTH = 4;
  localparam int NREQ  = 4;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] len;
  logic [NREQ-1:0]       gnt;
  logic [NREQ-1:0]       done;
  logic                  busy;
  logic [WIDTH-1:0]      count;

  int n_checks = 0;
  int n_errors = 0;

  logic [NREQ-1:0] exp_q[$];

  // Model: who holds the counter, how long it has run, who is finishing.
  int m_owner      = -1;
  int m_done_owner = -1;
  int m_elapsed    = 0;
  int m_tgt        = 0;
  int m_ptr        = 0;
  bit m_valid      = 1'b0;

  counter_sched #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .len   (len),
    .gnt   (gnt),
    .done  (done),
    .busy  (busy),
    .count (count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin : model
    int o, d, e, t, p, c;
    bit found;
    o = m_owner; d = m_done_owner; e = m_elapsed; t = m_tgt; p = m_ptr;
    found = 1'b0;
    if (rst) begin
      o = -1; d = -1; e = 0; t = 0; p = 0;
    end else if (d >= 0) begin
      d = -1;
    end else if (o >= 0) begin
      if (e == t) begin
        d = o; p = (o + 1) % NREQ; o = -1;
      end else if (!req[o]) begin
        p = (o + 1) % NREQ; o = -1;
      end else begin
        e = e + 1;
      end
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        c = (p + i) % NREQ;
        if (!found && req[c]) begin
          found = 1'b1;
          o = c;
          t = int'(len[c*WIDTH +: WIDTH]);
          e = 0;
        end
      end
    end
    m_owner      <= o;
    m_done_owner <= d;
    m_elapsed    <= e;
    m_tgt        <= t;
    m_ptr        <= p;
    if (rst) m_valid <= 1'b1;
  end

  always @(negedge clk) begin : compare
    logic [NREQ-1:0]  eg, ed;
    logic             eb;
    logic [WIDTH-1:0] ec;
    if (m_valid) begin
      eg = '0; ed = '0;
      if (m_owner >= 0) eg[m_owner] = 1'b1;
      if (m_done_owner >= 0) ed[m_done_owner] = 1'b1;
      eb = (m_owner >= 0) || (m_done_owner >= 0);
      if (m_owner >= 0) ec = WIDTH'(m_elapsed);
      else if (m_done_owner >= 0) ec = WIDTH'(m_tgt);
      else ec = '0;
      n_checks++;
      if (gnt !== eg || done !== ed || busy !== eb || count !== ec) begin
        n_errors++;
        $display("FAIL model_cmp t=%0t gnt=%b exp %b done=%b exp %b busy=%b exp %b count=%0d exp %0d",
                 $time, gnt, eg, done, ed, busy, eb, count, ec);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_cnt(input int v, input int budget, input string name);
    int k;
    k = 0;
    while (count !== WIDTH'(v) && k < budget) begin
      tick();
      k++;
    end
    chk(name, 32'(count), 32'(v));
  endtask

  task automatic pulse_reset();
    rst = 1'b1; req = '0;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    logic [NREQ-1:0] prev, e;
    rst = 1'b1; req = '0; len = '0;
    tick(); tick();
    chk("reset_gnt", 32'(gnt), 0);
    chk("reset_done", 32'(done), 0);
    chk("reset_busy", 32'(busy), 0);
    chk("reset_count", 32'(count), 0);
    rst = 1'b0;

    // Single run, len0=3.
    len = {4'd0, 4'd0, 4'd0, 4'd3}; req = 4'b0001;
    tick(); chk("single_gnt", 32'(gnt), 32'h1); chk("single_c0", 32'(count), 0);
    tick(); chk("single_c1", 32'(count), 1);
    tick(); chk("single_c2", 32'(count), 2);
    tick(); chk("single_c3", 32'(count), 3); chk("single_gnt_last", 32'(gnt), 32'h1);
    tick(); chk("single_done", 32'(done), 32'h1); chk("single_gnt_off", 32'(gnt), 0);
    chk("single_busy_done", 32'(busy), 1);
    req = '0;
    tick(); chk("single_done_off", 32'(done), 0); chk("single_count_end", 32'(count), 0);
    chk("single_busy_off", 32'(busy), 0);

    // Fairness: req0 and req2 alternate.
    pulse_reset();
    len = {4'd0, 4'd1, 4'd0, 4'd1};
    exp_q = {4'b0001, 4'b0100, 4'b0001, 4'b0100};
    req = 4'b0101; prev = '0;
    for (int k = 0; k < 40 && exp_q.size() > 0; k++) begin
      tick();
      if (gnt != '0 && prev == '0) begin
        e = exp_q.pop_front();
        chk("fair_order", 32'(gnt), 32'(e));
      end
      prev = gnt;
    end
    chk("fair_all_grants", exp_q.size(), 0);
    req = '0;
    repeat (4) tick();

    // Zero length on req3.
    len = {4'd0, 4'd5, 4'd5, 4'd5}; req = 4'b1000;
    tick(); chk("zero_gnt", 32'(gnt), 32'h8); chk("zero_count", 32'(count), 0);
    tick(); chk("zero_done", 32'(done), 32'h8); chk("zero_gnt_off", 32'(gnt), 0);
    req = '0;
    tick(); chk("zero_done_off", 32'(done), 0);

    // Abort req1 at count 4; next search starts at 2.
    pulse_reset();
    len = {4'd3, 4'd3, 4'd10, 4'd3}; req = 4'b0010;
    tick(); chk("abort_gnt", 32'(gnt), 32'h2);
    wait_cnt(4, 20, "abort_reach4");
    req = '0;
    tick(); chk("abort_gnt_off", 32'(gnt), 0); chk("abort_count", 32'(count), 0);
    chk("abort_no_done", 32'(done), 0);
    tick(); chk("abort_no_late_done", 32'(done), 0);
    req = 4'b1111;
    tick(); chk("abort_next_ptr", 32'(gnt), 32'h4);
    req = '0;
    repeat (3) tick();

    // Max length with req0 dropped on the final count.
    len = {4'd0, 4'd0, 4'd0, 4'd15}; req = 4'b0001;
    tick(); chk("max_gnt", 32'(gnt), 32'h1);
    wait_cnt(15, 25, "max_reach15");
    req = '0;
    tick(); chk("max_done", 32'(done), 32'h1); chk("max_count_hold", 32'(count), 15);
    tick(); chk("max_done_off", 32'(done), 0); chk("max_count_end", 32'(count), 0);

    // Reset during a run at count 5.
    len = {4'd0, 4'd0, 4'd7, 4'd10}; req = 4'b0001;
    tick();
    wait_cnt(5, 20, "rst_reach5");
    rst = 1'b1;
    tick();
    chk("rst_gnt", 32'(gnt), 0); chk("rst_done", 32'(done), 0);
    chk("rst_busy", 32'(busy), 0); chk("rst_count", 32'(count), 0);
    tick();
    chk("rst_no_done", 32'(done), 0);
    rst = 1'b0; req = 4'b0011;
    tick(); chk("rst_ptr0", 32'(gnt), 32'h1);
    req = '0;
    repeat (3) tick();

    // Random traffic, checked by the compare process.
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 3) == 0) req = NREQ'($urandom_range(0, 15));
      if ($urandom_range(0, 7) == 0) len = (NREQ*WIDTH)'($urandom());
      rst = ($urandom_range(0, 79) == 0);
      tick();
    end
    rst = 1'b0; req = '0;
    repeat (3) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/counter_sched.md
# counter_sched

Round-robin scheduler that shares one internal WIDTH-bit up-counter among NREQ requesters. Each requester asks for a timed interval of a programmed length. The scheduler grants the counter to one requester at a time, runs the count, and returns a one-cycle completion pulse. It sits between client blocks that need short delays or timeouts and the counter datapath, so each client no longer instantiates its own counter.

## Interface
- WIDTH, 4: counter and interval-length width in bits.
- NREQ, 4: number of requesters, 2..16.
- clk  input  1: single clock; all state changes on the rising edge.
- rst  input  1: synchronous reset, active-high.
- req  input  NREQ: per-requester request level; held high until done or abort.
- len  input  NREQ*WIDTH: packed interval targets; slice i is len[i*WIDTH +: WIDTH]; sampled only at grant.
- gnt  output  NREQ: one-hot grant, high for the whole run; reset 0.
- done  output  NREQ: one-hot, one-cycle completion pulse; reset 0.
- busy  output  1: high in RUN and DONE; reset 0.
- count  output  WIDTH: current counter value; reset 0.

## Operation
- States: IDLE, RUN, DONE. Reset forces IDLE, clears all outputs, sets ptr=0 and tgt=0.
- IDLE, req!=0: winner is the first set req bit searching from ptr upward, wrapping mod NREQ. At that edge:
  - gnt <= onehot(winner); owner <= winner
  - tgt <= len slice for winner
  - count <= 0; state <= RUN
- IDLE, req==0: hold. count stays 0.
- RUN, count==tgt: at the edge, state <= DONE, gnt <= 0, done <= onehot(owner). count holds tgt.
- RUN, req[owner]==0 and count!=tgt (abort): at the edge, state <= IDLE, gnt <= 0, count <= 0. No done pulse.
- RUN, otherwise: count <= count+1.
- DONE: at the edge, done <= 0, count <= 0, state <= IDLE.
- ptr update: on leaving RUN, by completion or abort, ptr <= (owner+1) mod NREQ.
- Simultaneous completion and req[owner] drop: completion wins and done pulses.
- Counter arithmetic is unsigned. count never exceeds tgt, so no wrap occurs. len=2^WIDTH-1 is legal and counts to all-ones.
- len=0: RUN lasts one cycle with count=0, then DONE.
- req bits of non-owners, and len changes after grant, have no effect until the next IDLE.
- rst asserted in any state: at the next edge, reset values are restored. Any in-flight run is dropped with no done.

## Timing
- All outputs are registered. No combinational path from inputs to outputs.
- Grant latency: req seen high in IDLE at edge k gives gnt high after edge k.
- gnt is high for exactly tgt+1 cycles, with count showing 0..tgt.
- done is high for the single cycle immediately after gnt falls.
- Minimum spacing between runs is DONE plus IDLE. Back-to-back grants are therefore separated by 2 cycles with gnt low.
- Abort: gnt falls one edge after req[owner] is sampled low.

## Structure
- Package counter_sched_pkg holds:
  - state typedef: enum logic [1:0] {IDLE, RUN, DONE}
  - function onehot(idx, NREQ)
- Sub-module rr_pick (combinational):
  - inputs: req, ptr
  - outputs: valid, idx
  - rotates req by ptr, priority-encodes, and un-rotates.
- Top holds the FSM, the ptr/owner/tgt registers and the counter.

## Test plan
Bench settings: WIDTH=4, NREQ=4, 10 ns clock.
- Reset: assert rst 2 cycles during a RUN with count=5 -> gnt=0, done=0, busy=0 and count=0 after the first rst edge; a later request is granted to req0 first (ptr=0).
- Single run: req=0001, len0=3 -> gnt=0001 for 4 cycles with count 0,1,2,3; done=0001 for 1 cycle; busy high 5 cycles; count=0 afterwards.
- Fairness: req=0101 held, len0=len2=1 -> grant order 0,2,0,2; each gnt is 2 cycles; 2-cycle gap between grants.
- Zero length: req=1000, len3=0 -> gnt=1000 for 1 cycle with count=0; done=1000 the next cycle.
- Abort: req=0010, len1=10, drop req1 when count=4 -> gnt=0 and count=0 one edge later; no done; next grant searches from ptr=2.
- Max length and collision: len0=15 -> count reaches 15 without wrap. req0 dropped in the same cycle count==15 -> done=0001 still pulses.
